// File: rtl/seg7_pkg.sv
// Shared constants and the nibble-to-segment encoder for the multiplexed
// 7-segment display driver. Segment order is {a,b,c,d,e,f,g}, 1 = lit.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  // Codes 10-14 fall back to the legacy 7448 glyphs unless hex_mode is set.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble,
                                             input logic       hex_mode);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = hex_mode ? 7'h77 : 7'h0D;
      4'hB: seg = hex_mode ? 7'h1F : 7'h19;
      4'hC: seg = hex_mode ? 7'h4E : 7'h23;
      4'hD: seg = hex_mode ? 7'h3D : 7'h4B;
      4'hE: seg = hex_mode ? 7'h4F : 7'h0F;
      default: seg = hex_mode ? 7'h47 : SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; one instance sits on the digit mux
// output of the scan driver.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_encode(nibble_i, HEX_MODE != 0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-cathode display driver: shadow register, scan
// prescaler with a dark guard cycle per slot, and leading-zero ripple blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    load,
  input  logic                    LT,
  input  logic                    RBI,
  input  logic                    BI,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    rbo
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    rbo_q, rbo_d;

  logic [NUM_DIGITS-1:0]   zero_above;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              nibble;
  logic                    sel_blank;
  logic                    guard;
  logic [6:0]              dec_seg;

  always_comb begin
    shadow_d = load ? data : shadow_q;
    presc_d  = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (presc_q == PRE_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // zero_above[k]: every nibble from the MSD down to digit k is zero.
  always_comb begin
    zero_above = '0;
    blank_mask = '0;
    zero_above[NUM_DIGITS-1] = (shadow_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (shadow_q[4*k +: 4] == 4'h0);
    end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      blank_mask[k] = RBI && zero_above[k];
    end
  end

  always_comb begin
    nibble    = 4'h0;
    sel_blank = 1'b0;
    onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nibble    = shadow_q[4*k +: 4];
        sel_blank = blank_mask[k];
        onehot[k] = 1'b1;
      end
    end
  end

  seg7_decode #(
    .HEX_MODE (HEX_MODE)
  ) u_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  // The guard cycle darkens segments too, except under lamp test.
  always_comb begin
    guard = (presc_q == '0);
    dig_d = guard ? '0 : onehot;
    rbo_d = RBI && zero_above[0];
    if (BI) begin
      seg_d = SEG_OFF;
    end else if (LT) begin
      seg_d = SEG_ALL;
    end else if (guard || sel_blank) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= '0;
      rbo_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      rbo_q    <= rbo_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;
  assign rbo     = rbo_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (7448 and hex encodings) share the
// stimulus; a cycle model feeds a scoreboard, plus directed per-slot checks.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   data  = '0;
  logic          load  = 1'b0;
  logic          LT    = 1'b0;
  logic          RBI   = 1'b0;
  logic          BI    = 1'b0;
  logic [6:0]    seg0, seg1;
  logic [3:0]    dig0, dig1;
  logic          rbo0, rbo1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [3:0] d;
    logic       r;
  } exp_t;

  exp_t exp_q[$];
  exp_t chk_e;

  logic [15:0] m_shadow;
  int          m_presc;
  int          m_idx;

  logic [6:0] ENC0 [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h0D, 7'h19, 7'h23, 7'h4B, 7'h0F, 7'h00};
  logic [6:0] ENC1 [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .LT(LT), .RBI(RBI),
    .BI(BI), .seg(seg0), .dig_sel(dig0), .rbo(rbo0));

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data(data), .load(load), .LT(LT), .RBI(RBI),
    .BI(BI), .seg(seg1), .dig_sel(dig1), .rbo(rbo1));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  // Expected registered outputs, derived from the model state before the edge.
  function automatic exp_t model_out();
    exp_t       e;
    int         lz;
    logic [3:0] nib;
    bit         guard, blank;
    lz = 0;
    for (int k = 3; k >= 0; k--) begin
      if (m_shadow[4*k +: 4] == 4'h0 && lz == 3 - k) lz++;
    end
    guard = (m_presc == 0);
    nib   = 4'(m_shadow >> (4 * m_idx));
    blank = RBI && (m_idx != 0) && (m_idx >= ND - lz);
    e.d   = guard ? 4'b0000 : 4'(1 << m_idx);
    e.r   = RBI && (m_shadow == 16'h0000);
    if (BI) begin
      e.s0 = 7'h00; e.s1 = 7'h00;
    end else if (LT) begin
      e.s0 = 7'h7F; e.s1 = 7'h7F;
    end else if (guard || blank) begin
      e.s0 = 7'h00; e.s1 = 7'h00;
    end else begin
      e.s0 = ENC0[nib]; e.s1 = ENC1[nib];
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_shadow <= '0;
      m_presc  <= 0;
      m_idx    <= 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out());
      if (load) m_shadow <= data;
      if (m_presc == SD - 1) begin
        m_presc <= 0;
        m_idx   <= (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
        m_presc <= m_presc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      chk_e = exp_q.pop_front();
      check_val("sb_seg_h0", 32'(seg0), 32'(chk_e.s0));
      check_val("sb_seg_h1", 32'(seg1), 32'(chk_e.s1));
      check_val("sb_dig_h0", 32'(dig0), 32'(chk_e.d));
      check_val("sb_dig_h1", 32'(dig1), 32'(chk_e.d));
      check_val("sb_rbo",    32'(rbo0), 32'(chk_e.r));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d);
    @(negedge clk);
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic expect_slot(input string tag, input int d, input bit hex, input logic [6:0] want);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig0 !== 4'(1 << d) && n < 40);
    check_val({tag, "_slot"}, 32'(dig0), 32'(1 << d));
    check_val(tag, 32'(hex ? seg1 : seg0), 32'(want));
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    cycles(3);
    check_val("rst_seg", 32'(seg0), 32'h00);
    check_val("rst_dig", 32'(dig0), 32'h0);
    check_val("rst_rbo", 32'(rbo0), 32'h0);
    rst_n = 1'b1;

    // Scan walk from reset, shadow still zero.
    cycles(20);
    expect_slot("t1_d0", 0, 0, 7'h7E);

    do_load(16'h1208);
    expect_slot("t2_d0", 0, 0, 7'h7F);
    expect_slot("t2_d1", 1, 0, 7'h7E);
    expect_slot("t2_d2", 2, 0, 7'h6D);
    expect_slot("t2_d3", 3, 0, 7'h30);

    RBI = 1'b1;
    do_load(16'h0005);
    expect_slot("t3_d1", 1, 0, 7'h00);
    expect_slot("t3_d2", 2, 0, 7'h00);
    expect_slot("t3_d3", 3, 0, 7'h00);
    expect_slot("t3_d0", 0, 0, 7'h5B);
    check_val("t3_rbo0", 32'(rbo0), 32'h0);
    do_load(16'h0000);
    expect_slot("t3_z_d0", 0, 0, 7'h7E);
    check_val("t3_rbo1", 32'(rbo0), 32'h1);
    do_load(16'h0300);
    expect_slot("t3_mid_d1", 1, 0, 7'h7E);
    RBI = 1'b0;

    // Encoder sweep through every nibble in both modes.
    do_load(16'h3210); cycles(16);
    do_load(16'h7654); cycles(16);
    do_load(16'hBA98); cycles(16);
    do_load(16'hFEDC); cycles(16);

    do_load(16'h1208);
    LT = 1'b1;
    cycles(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("t4_lt", 32'(seg0), 32'h7F);
    end
    BI = 1'b1;
    cycles(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("t4_bi", 32'(seg0), 32'h00);
    end
    LT = 1'b0;
    cycles(6);
    BI = 1'b0;

    do_load(16'hFA0C);
    expect_slot("t5_h1_d0", 0, 1, 7'h4E);
    expect_slot("t5_h1_d1", 1, 1, 7'h7E);
    expect_slot("t5_h1_d2", 2, 1, 7'h77);
    expect_slot("t5_h1_d3", 3, 1, 7'h47);
    expect_slot("t5_h0_d3", 3, 0, 7'h00);
    expect_slot("t5_h0_d2", 2, 0, 7'h0D);

    // Asynchronous reset in the middle of a lit slot.
    do_load(16'h1208);
    expect_slot("t6_pre", 2, 0, 7'h6D);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("t6_async_seg", 32'(seg0), 32'h00);
    check_val("t6_async_dig", 32'(dig0), 32'h0);
    @(negedge clk);
    data = 16'hFFFF;
    load = 1'b1;
    cycles(2);
    check_val("t6_hold_seg", 32'(seg0), 32'h00);
    rst_n = 1'b1;
    load  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig0 === 4'b0000 && n < 20);
    check_val("t6_first_slot", 32'(dig0), 32'h1);
    check_val("t6_first_seg", 32'(seg0), 32'h7E);
    cycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
